// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-ported data memory between an
// instruction-fetch port (0) and a load/store port (1); all outputs registered.
module dmem_arbiter #(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 32,
  parameter int LATENCY = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                p0_req,
  input  logic                p0_we,
  input  logic [ADDR_W-1:0]   p0_addr,
  input  logic [DATA_W-1:0]   p0_wdata,
  input  logic [DATA_W/8-1:0] p0_wstrb,
  output logic                p0_ack,
  output logic [DATA_W-1:0]   p0_rdata,
  input  logic                p1_req,
  input  logic                p1_we,
  input  logic [ADDR_W-1:0]   p1_addr,
  input  logic [DATA_W-1:0]   p1_wdata,
  input  logic [DATA_W/8-1:0] p1_wstrb,
  output logic                p1_ack,
  output logic [DATA_W-1:0]   p1_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy,
  output logic                grant_id
);

  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

  state_t state_reg, state_next;

  logic              last_grant_reg, last_grant_next;
  logic              grant_reg, grant_next;
  logic              we_reg, we_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              mem_en_reg, mem_en_next;
  logic              mem_we_reg, mem_we_next;
  logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
  logic [DATA_W-1:0] mem_wdata_reg, mem_wdata_next;
  logic [STRB_W-1:0] mem_wstrb_reg, mem_wstrb_next;
  logic              busy_reg, busy_next;
  logic [1:0]        ack_next;
  logic [1:0]        capture;
  logic              ack_reg [2];
  logic [DATA_W-1:0] rdata_reg [2];

  logic [1:0]        req_vec;
  logic              cmd_we [2];
  logic [ADDR_W-1:0] cmd_addr [2];
  logic [DATA_W-1:0] cmd_wdata [2];
  logic [STRB_W-1:0] cmd_wstrb [2];
  logic              win;

  assign req_vec      = {p1_req, p0_req};
  assign cmd_we[0]    = p0_we;
  assign cmd_we[1]    = p1_we;
  assign cmd_addr[0]  = p0_addr;
  assign cmd_addr[1]  = p1_addr;
  assign cmd_wdata[0] = p0_wdata;
  assign cmd_wdata[1] = p1_wdata;
  assign cmd_wstrb[0] = p0_wstrb;
  assign cmd_wstrb[1] = p1_wstrb;

  // On a tie the port that did not win last time goes first.
  assign win = (req_vec == 2'b11) ? ~last_grant_reg : req_vec[1];

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next      = state_reg;
    last_grant_next = last_grant_reg;
    grant_next      = grant_reg;
    we_next         = we_reg;
    cnt_next        = cnt_reg;
    mem_en_next     = 1'b0;
    mem_we_next     = 1'b0;
    mem_wstrb_next  = '0;
    mem_addr_next   = mem_addr_reg;
    mem_wdata_next  = mem_wdata_reg;
    ack_next        = 2'b00;
    capture         = 2'b00;
    case (state_reg)
      IDLE: begin
        if (|req_vec) begin
          grant_next      = win;
          last_grant_next = win;
          we_next         = cmd_we[win];
          // The latched command is presented on the memory side for ISSUE.
          mem_en_next     = 1'b1;
          mem_we_next     = cmd_we[win];
          mem_addr_next   = cmd_addr[win];
          mem_wdata_next  = cmd_wdata[win];
          mem_wstrb_next  = cmd_we[win] ? cmd_wstrb[win] : '0;
          state_next      = ISSUE;
        end
      end
      ISSUE: begin
        if (we_reg) begin
          ack_next[grant_reg] = 1'b1;
          state_next          = ACK;
        end else begin
          cnt_next   = CNT_W'(LATENCY - 1);
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (cnt_reg == '0) begin
          capture[grant_reg]  = 1'b1;
          ack_next[grant_reg] = 1'b1;
          state_next          = ACK;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      ACK: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_reg <= 1'b1;
      grant_reg      <= 1'b0;
      we_reg         <= 1'b0;
      cnt_reg        <= '0;
      mem_en_reg     <= 1'b0;
      mem_we_reg     <= 1'b0;
      mem_addr_reg   <= '0;
      mem_wdata_reg  <= '0;
      mem_wstrb_reg  <= '0;
      busy_reg       <= 1'b0;
    end else begin
      last_grant_reg <= last_grant_next;
      grant_reg      <= grant_next;
      we_reg         <= we_next;
      cnt_reg        <= cnt_next;
      mem_en_reg     <= mem_en_next;
      mem_we_reg     <= mem_we_next;
      mem_addr_reg   <= mem_addr_next;
      mem_wdata_reg  <= mem_wdata_next;
      mem_wstrb_reg  <= mem_wstrb_next;
      busy_reg       <= busy_next;
    end
  end

  // Per-port response registers; only the granted port ever captures.
  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    always_ff @(posedge clk) begin
      if (rst) begin
        ack_reg[gi]   <= 1'b0;
        rdata_reg[gi] <= '0;
      end else begin
        ack_reg[gi] <= ack_next[gi];
        if (capture[gi]) rdata_reg[gi] <= mem_rdata;
      end
    end
  end

  assign p0_ack    = ack_reg[0];
  assign p1_ack    = ack_reg[1];
  assign p0_rdata  = rdata_reg[0];
  assign p1_rdata  = rdata_reg[1];
  assign mem_en    = mem_en_reg;
  assign mem_we    = mem_we_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign mem_wstrb = mem_wstrb_reg;
  assign busy      = busy_reg;
  assign grant_id  = grant_reg;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed vector table, multi-cycle sequences and a
// randomized run against a transaction-level timing/memory model.
`timescale 1ns/1ps
module tb_dmem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [9:0]  p0_addr, p1_addr;
  logic [31:0] p0_wdata, p1_wdata;
  logic [3:0]  p0_wstrb, p1_wstrb;
  logic        p0_ack, p1_ack;
  logic [31:0] p0_rdata, p1_rdata;
  logic        mem_en, mem_we, busy, grant_id;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  // second instance at LATENCY=3, only port 0 used
  logic        b_p0_req, b_p0_we, b_p1_req, b_p1_we;
  logic [9:0]  b_p0_addr, b_p1_addr;
  logic [31:0] b_p0_wdata, b_p1_wdata;
  logic [3:0]  b_p0_wstrb, b_p1_wstrb;
  logic        b_p0_ack, b_p1_ack;
  logic [31:0] b_p0_rdata, b_p1_rdata;
  logic        b_mem_en, b_mem_we, b_busy, b_grant_id;
  logic [9:0]  b_mem_addr;
  logic [31:0] b_mem_wdata, b_mem_rdata;
  logic [3:0]  b_mem_wstrb;

  dmem_arbiter #(.ADDR_W(10), .DATA_W(32), .LATENCY(1)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_wstrb(p0_wstrb), .p0_ack(p0_ack), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_wstrb(p1_wstrb), .p1_ack(p1_ack), .p1_rdata(p1_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .busy(busy), .grant_id(grant_id)
  );

  dmem_arbiter #(.ADDR_W(10), .DATA_W(32), .LATENCY(3)) dut3 (
    .clk(clk), .rst(rst),
    .p0_req(b_p0_req), .p0_we(b_p0_we), .p0_addr(b_p0_addr), .p0_wdata(b_p0_wdata),
    .p0_wstrb(b_p0_wstrb), .p0_ack(b_p0_ack), .p0_rdata(b_p0_rdata),
    .p1_req(b_p1_req), .p1_we(b_p1_we), .p1_addr(b_p1_addr), .p1_wdata(b_p1_wdata),
    .p1_wstrb(b_p1_wstrb), .p1_ack(b_p1_ack), .p1_rdata(b_p1_rdata),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_wstrb(b_mem_wstrb), .mem_rdata(b_mem_rdata), .busy(b_busy), .grant_id(b_grant_id)
  );

  // Memory models; idle read-data is poisoned so a mistimed capture shows up.
  bit   [31:0] mem1 [1024];
  bit   [31:0] mem3 [1024];
  logic [31:0] pipe3 [3];

  always @(posedge clk) begin
    if (mem_en && mem_we)
      for (int i = 0; i < 4; i++)
        if (mem_wstrb[i]) mem1[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
    mem_rdata <= (mem_en && !mem_we) ? mem1[mem_addr] : 32'hBAD0BAD0;
  end

  always @(posedge clk) begin
    if (b_mem_en && b_mem_we)
      for (int i = 0; i < 4; i++)
        if (b_mem_wstrb[i]) mem3[b_mem_addr][8*i +: 8] <= b_mem_wdata[8*i +: 8];
    pipe3[0] <= (b_mem_en && !b_mem_we) ? mem3[b_mem_addr] : 32'hBAD0BAD0;
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign b_mem_rdata = pipe3[2];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input int p, input bit req, input bit we, input logic [9:0] addr,
                       input logic [31:0] wd, input logic [3:0] st);
    if (p == 0) begin
      p0_req = req; p0_we = we; p0_addr = addr; p0_wdata = wd; p0_wstrb = st;
    end else begin
      p1_req = req; p1_we = we; p1_addr = addr; p1_wdata = wd; p1_wstrb = st;
    end
  endtask

  // Leaves the bench at a falling edge of an IDLE cycle ("cycle 0").
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive(0, 0, 0, '0, '0, '0);
    drive(1, 0, 0, '0, '0, '0);
    b_p0_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, " acks"}, {p0_ack, p1_ack}, 0);
    check({tag, " rdata"}, {p0_rdata, p1_rdata}, 0);
    check({tag, " mem ctl"}, {mem_en, mem_we, mem_wstrb}, 0);
    check({tag, " mem addr/data"}, {mem_addr, mem_wdata}, 0);
    check({tag, " busy/grant"}, {busy, grant_id}, 0);
  endtask

  typedef struct {
    int          port;
    bit          we;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          lat;
    logic [31:0] rdata;
  } vec_t;

  task automatic txn(input vec_t v, input string name);
    int en_k, ack_k;
    bit other;
    logic [31:0] rd;
    en_k = -1; ack_k = -1; other = 0; rd = '0;
    drive(v.port, 1, v.we, v.addr, v.wdata, v.strb);
    for (int k = 1; k <= 20 && ack_k < 0; k++) begin
      @(negedge clk);
      if (mem_en && en_k < 0) begin
        en_k = k;
        check({name, " mem_we"}, mem_we, v.we);
        check({name, " mem_addr"}, mem_addr, v.addr);
        check({name, " mem_wstrb"}, mem_wstrb, v.we ? v.strb : 4'h0);
        if (v.we) check({name, " mem_wdata"}, mem_wdata, v.wdata);
      end
      if (v.port == 0 ? p1_ack : p0_ack) other = 1;
      if (v.port == 0 ? p0_ack : p1_ack) begin
        ack_k = k;
        rd = (v.port == 0) ? p0_rdata : p1_rdata;
      end
    end
    check({name, " en cycle"}, en_k, 1);
    check({name, " ack cycle"}, ack_k, v.lat);
    check({name, " other ack"}, other, 0);
    if (!v.we) check({name, " rdata"}, rd, v.rdata);
    @(negedge clk);
    drive(v.port, 0, 0, '0, '0, '0);
  endtask

  localparam int N_RAND = 600;
  localparam int NC     = N_RAND + 16;

  initial begin
    vec_t vecs[9];
    vec_t v;
    int nack, port;
    bit got;
    logic [9:0]  ba [3];
    logic [31:0] bd [3];
    // random-run model state
    bit   [31:0] ref_mem [1024];
    int   ev_ack [NC];
    bit   ev_rd [NC];
    logic [31:0] ev_data [NC];
    bit   ev_en [NC];
    bit   ev_busy [NC];
    int   ev_gid [NC];
    bit   act [2];
    int   done_at [2];
    bit   c_we [2];
    logic [9:0]  c_ad [2];
    logic [31:0] c_wd [2];
    logic [3:0]  c_st [2];
    logic [31:0] m_rd [2];
    int   m_last, m_gid, next_free, w, ackc;

    rst = 1'b1;
    b_p0_req = 0; b_p0_we = 0; b_p0_addr = '0; b_p0_wdata = '0; b_p0_wstrb = '0;
    b_p1_req = 0; b_p1_we = 0; b_p1_addr = '0; b_p1_wdata = '0; b_p1_wstrb = '0;

    vecs[0] = '{0, 1, 10'h005, 32'hDEADBEEF, 4'hF, 2, 32'h0};
    vecs[1] = '{1, 0, 10'h005, 32'h0,        4'hF, 3, 32'hDEADBEEF};
    vecs[2] = '{0, 1, 10'h3FF, 32'h12345678, 4'h3, 2, 32'h0};
    vecs[3] = '{1, 0, 10'h3FF, 32'h0,        4'h0, 3, 32'h00005678};
    vecs[4] = '{1, 1, 10'h3FF, 32'hAABBCCDD, 4'hC, 2, 32'h0};
    vecs[5] = '{0, 0, 10'h3FF, 32'h0,        4'h0, 3, 32'hAABB5678};
    vecs[6] = '{0, 1, 10'h000, 32'hFFFFFFFF, 4'h5, 2, 32'h0};
    vecs[7] = '{1, 0, 10'h000, 32'h0,        4'h0, 3, 32'h00FF00FF};
    vecs[8] = '{0, 0, 10'h2AA, 32'h0,        4'hF, 3, 32'h0};

    do_reset();
    check_zero("reset");
    for (int i = 0; i < 9; i++) txn(vecs[i], $sformatf("vec%0d", i));

    // Both ports hold read requests: grants alternate, acks every 4 cycles.
    do_reset();
    drive(0, 1, 0, 10'h3FF, '0, '0);
    drive(1, 1, 0, 10'h005, '0, '0);
    nack = 0;
    for (int k = 1; k <= 30 && nack < 4; k++) begin
      @(negedge clk);
      if (p0_ack && p1_ack) check("alt double ack", 1, 0);
      else if (p0_ack || p1_ack) begin
        port = p1_ack ? 1 : 0;
        check($sformatf("alt%0d port", nack), port, nack % 2);
        check($sformatf("alt%0d cycle", nack), k, 3 + 4 * nack);
        check($sformatf("alt%0d grant_id", nack), grant_id, port);
        check($sformatf("alt%0d rdata", nack), port ? p1_rdata : p0_rdata,
              port ? 32'hDEADBEEF : 32'hAABB5678);
        nack++;
      end
    end
    check("alt ack count", nack, 4);
    @(negedge clk);
    drive(0, 0, 0, '0, '0, '0);
    drive(1, 0, 0, '0, '0, '0);

    // LATENCY=3 instance: write a word, then time the read exactly.
    do_reset();
    b_p0_req = 1; b_p0_we = 1; b_p0_addr = 10'h010; b_p0_wdata = 32'hCAFEF00D; b_p0_wstrb = 4'hF;
    got = 0;
    for (int k = 1; k <= 10 && !got; k++) begin
      @(negedge clk);
      if (b_p0_ack) got = 1;
    end
    check("lat3 write ack", got, 1);
    @(negedge clk);
    b_p0_we = 0; b_p0_wdata = '0; b_p0_wstrb = '0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check($sformatf("lat3 busy k%0d", k), b_busy, (k >= 1 && k <= 5));
      check($sformatf("lat3 mem_en k%0d", k), b_mem_en, (k == 1));
      check($sformatf("lat3 ack k%0d", k), {b_p1_ack, b_p0_ack}, {1'b0, k == 5});
      if (k == 5) check("lat3 rdata", b_p0_rdata, 32'hCAFEF00D);
      if (k == 6) b_p0_req = 0;
    end

    // Reset during the WAIT of a p1 read; then a tie goes to port 0.
    do_reset();
    drive(1, 1, 0, 10'h005, '0, '0);
    @(negedge clk);
    check("rstw issue en", mem_en, 1);
    check("rstw issue grant", grant_id, 1);
    @(negedge clk);
    check("rstw wait busy", busy, 1);
    rst = 1'b1;
    drive(1, 0, 0, '0, '0, '0);
    @(negedge clk);
    check_zero("rstw after");
    rst = 1'b0;
    drive(0, 1, 0, 10'h3FF, '0, '0);
    drive(1, 1, 0, 10'h005, '0, '0);
    @(negedge clk);
    check("rstw tie grant", grant_id, 0);
    check("rstw tie en", mem_en, 1);
    for (int k = 5; k <= 7; k++) begin
      @(negedge clk);
      check($sformatf("rstw ack k%0d", k), {p1_ack, p0_ack}, {1'b0, k == 6});
      if (k == 7) begin
        drive(0, 0, 0, '0, '0, '0);
        drive(1, 0, 0, '0, '0, '0);
      end
    end

    // p1 back-to-back writes with req held; new command after each ack.
    ba = '{10'h040, 10'h041, 10'h042};
    bd = '{32'h11111111, 32'h22222222, 32'h33333333};
    do_reset();
    nack = 0;
    drive(1, 1, 1, ba[0], bd[0], 4'hF);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      check($sformatf("b2b en k%0d", k), mem_en, k inside {1, 4, 7});
      check($sformatf("b2b ack k%0d", k), {p0_ack, p1_ack}, {1'b0, k inside {2, 5, 8}});
      if (mem_en) check($sformatf("b2b cmd k%0d", k), {mem_addr, mem_wdata}, {ba[nack], bd[nack]});
      if (k == 3 || k == 6) begin
        nack++;
        drive(1, 1, 1, ba[nack], bd[nack], 4'hF);
      end
      if (k == 9) drive(1, 0, 0, '0, '0, '0);
    end
    v = '{0, 0, 10'h041, 32'h0, 4'h0, 3, 32'h22222222};
    txn(v, "b2b readback");

    // Randomized traffic against a transaction-level model.
    for (int c = 0; c < NC; c++) begin
      ev_ack[c] = -1; ev_rd[c] = 0; ev_data[c] = '0;
      ev_en[c] = 0; ev_busy[c] = 0; ev_gid[c] = -1;
    end
    for (int p = 0; p < 2; p++) begin
      act[p] = 0; done_at[p] = -10; m_rd[p] = '0;
      c_we[p] = 0; c_ad[p] = '0; c_wd[p] = '0; c_st[p] = '0;
    end
    m_last = 1; m_gid = 0; next_free = 0;
    do_reset();
    for (int c = 0; c < N_RAND; c++) begin
      if (c > 0) @(negedge clk);
      if (ev_gid[c] >= 0) m_gid = ev_gid[c];
      if (ev_ack[c] >= 0 && ev_rd[c]) m_rd[ev_ack[c]] = ev_data[c];
      check($sformatf("rnd c%0d acks", c), {p1_ack, p0_ack},
            {ev_ack[c] == 1, ev_ack[c] == 0});
      check($sformatf("rnd c%0d en/busy", c), {mem_en, busy}, {ev_en[c], ev_busy[c]});
      check($sformatf("rnd c%0d grant", c), grant_id, m_gid);
      check($sformatf("rnd c%0d rdata", c), {p1_rdata, p0_rdata}, {m_rd[1], m_rd[0]});
      // requesters
      for (int p = 0; p < 2; p++) begin
        if (act[p] && done_at[p] == c - 1) act[p] = 0;
        if (!act[p] && $urandom_range(0, 2) != 0) begin
          act[p] = 1; done_at[p] = -10;
          c_we[p] = $urandom_range(0, 1);
          c_ad[p] = 10'h100 + 10'($urandom_range(0, 15));
          c_wd[p] = $urandom;
          c_st[p] = 4'($urandom_range(0, 15));
        end
        drive(p, act[p], c_we[p], c_ad[p], c_wd[p], c_st[p]);
      end
      // arbiter model: free cycle with a pending request starts a transaction
      if (c >= next_free && (act[0] || act[1])) begin
        w = (act[0] && act[1]) ? 1 - m_last : (act[1] ? 1 : 0);
        m_last = w;
        ackc = c + (c_we[w] ? 2 : 3);
        done_at[w] = ackc;
        next_free = ackc + 1;
        ev_en[c + 1] = 1;
        ev_gid[c + 1] = w;
        for (int t = c + 1; t <= ackc; t++) ev_busy[t] = 1;
        ev_ack[ackc] = w;
        if (c_we[w]) begin
          for (int i = 0; i < 4; i++)
            if (c_st[w][i]) ref_mem[c_ad[w]][8*i +: 8] = c_wd[w][8*i +: 8];
        end else begin
          ev_rd[ackc] = 1;
          ev_data[ackc] = ref_mem[c_ad[w]];
        end
      end
    end
    @(negedge clk);
    drive(0, 0, 0, '0, '0, '0);
    drive(1, 0, 0, '0, '0, '0);
    repeat (5) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares one single-ported, word-addressed data memory between two requesters.
- Port 0 is the instruction-fetch side; port 1 is the load/store stage.
- Serialises accesses with a round-robin grant and sequences the memory's fixed read latency.
- Returns read data and a one-cycle acknowledge to the winning port.

Parameters:
- ADDR_W, 10: word-address width; memory depth is 2^ADDR_W words.
- DATA_W, 32: data width; must be a multiple of 8.
- LATENCY, 1: memory read latency in cycles, >=1. mem_rdata is valid LATENCY cycles after the mem_en cycle.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- p0_req  in  1  port 0 request; held with command stable until p0_ack.
- p0_we  in  1  port 0 write (1) / read (0).
- p0_addr  in  ADDR_W  port 0 word address.
- p0_wdata  in  DATA_W  port 0 write data.
- p0_wstrb  in  DATA_W/8  port 0 byte enables; ignored for reads.
- p0_ack  out  1  one-cycle completion pulse for port 0.
- p0_rdata  out  DATA_W  port 0 read data; valid while p0_ack=1.
- p1_req / p1_we / p1_addr / p1_wdata / p1_wstrb / p1_ack / p1_rdata: same as port 0, for port 1.
- mem_en  out  1  memory access strobe, one cycle per transaction.
- mem_we  out  1  memory write enable; asserted only together with mem_en.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_wstrb  out  DATA_W/8  memory byte enables; 0 on reads.
- mem_rdata  in  DATA_W  memory read data.
- busy  out  1  1 in any state other than IDLE.
- grant_id  out  1  port that owns the current transaction.

Behaviour:
- All outputs are registered.
- Reset values: every output is 0; state=IDLE; last_grant=1, so port 0 wins the first tie.
- FSM states: IDLE, ISSUE, WAIT, ACK.
- IDLE:
  - No request: stay in IDLE.
  - Exactly one request: grant that port.
  - Both requesting: grant the port opposite last_grant.
  - On a grant: latch the winner's we, addr, wdata and wstrb; set grant_id and last_grant; go to ISSUE.
- ISSUE (exactly one cycle):
  - mem_en=1, mem_we=latched we, mem_addr, mem_wdata and mem_wstrb from the latched command; wstrb is forced to 0 when we=0.
  - Write: next state is ACK.
  - Read: load the wait counter with LATENCY-1, then go to WAIT.
- WAIT (LATENCY cycles): decrement the counter. When it reaches 0, capture mem_rdata into the granted port's rdata register and go to ACK.
- ACK (one cycle):
  - Granted port's ack=1; rdata holds the captured word (reads). For writes rdata keeps its previous value.
  - Next state is IDLE.
- Timing: with req sampled in IDLE at cycle T, mem_en is high in T+1. Ack is high in T+2 for a write and in T+2+LATENCY for a read.
- A requester drops or replaces req in the cycle after ack. Req seen in IDLE always means a new command, which gives back-to-back service with no duplicate grant.
- Requests are not sampled in ISSUE, WAIT or ACK; they wait for IDLE.
- The non-granted port's ack stays 0 and its rdata is unchanged.
- Fairness: a continuously requesting port waits at most one foreign transaction.
- Memory-side signals: outside ISSUE, mem_en=0, mem_we=0, mem_wstrb=0. mem_addr and mem_wdata hold their last values.
- Reset mid-transaction: return to IDLE next cycle with all outputs 0. Any in-flight read result is discarded and no ack is issued; last_grant returns to 1.
- Address width: addr is passed through unmodified; no range check, since the full ADDR_W space is valid.

Test Plan:
- Reset, then p1 reads addr 0x005 with memory word 0x005 = 0xDEADBEEF at LATENCY=1, req at cycle 0 -> mem_en at cycle 1, p1_ack=1 and p1_rdata=0xDEADBEEF at cycle 3, p0_ack=0 throughout.
- p0 writes addr 0x3FF, data 0x12345678, wstrb 4'b0011 -> mem_en=mem_we=1 and mem_wstrb=4'b0011 in cycle 1; p0_ack at cycle 2; a subsequent p1 read of 0x3FF returns 0x00005678 when the memory was 0 before the write.
- p0 and p1 both hold req continuously (reads) -> grants alternate 0,1,0,1 (grant_id sequence); each ack spaced 4 cycles apart at LATENCY=1.
- LATENCY=3, p0 read -> mem_en at cycle 1, WAIT for 3 cycles, p0_ack at cycle 5; busy high in cycles 1-5.
- Assert rst during WAIT of a p1 read -> next cycle state IDLE, all outputs 0, no p1_ack ever. A following simultaneous request is granted to port 0.
- p1 issues back-to-back writes (req held, new addr/data in the cycle after each ack) -> exactly one mem_en per write, acks at cycles 2, 5, 8; no duplicate write.
